// File: rtl/gray_codec_pipe.sv
// Pipelined binary<->Gray converter with per-word mode and valid/ready on both sides.
// Optional Gray step checker enabled by defining GRAY_CODEC_STEP_CHECK_EN.
module gray_codec_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             gray_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_gray_n,
  output logic             step_err
);

  localparam int CHUNK = (WIDTH + STAGES - 1) / STAGES;
  localparam int LAST  = STAGES - 1;

  logic [STAGES-1:0] r_vld;
  logic [WIDTH-1:0]  r_data [STAGES];
  logic [STAGES-1:0] r_mode;
  logic [STAGES-1:0] r_err;

  logic [STAGES-1:0] w_rdy;
  logic [STAGES-1:0] w_src_vld;
  logic [WIDTH-1:0]  w_src_data [STAGES];
  logic [STAGES-1:0] w_src_mode;
  logic [STAGES-1:0] w_src_err;
  logic              w_step_err_in;

  // Stage k resolves its slice of Gray bits MSB-first; bits above the slice are already binary,
  // so the resolved carry travels inside the word itself.
  function automatic logic [WIDTH-1:0] f_resolve(input logic [WIDTH-1:0] x, input int k);
    logic [WIDTH-1:0] r;
    int hi;
    int lo;
    r  = x;
    hi = WIDTH - 1 - k * CHUNK;
    lo = (k == LAST) ? 0 : WIDTH - (k + 1) * CHUNK;
    if (lo < 0) lo = 0;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (i <= hi && i >= lo) r[i] = r[i+1] ^ r[i];
    end
    return r;
  endfunction

`ifdef GRAY_CODEC_STEP_CHECK_EN
  logic [WIDTH-1:0] r_hist;
  logic             r_hist_vld;
  logic             w_in_fire;
  logic [WIDTH-1:0] w_diff;

  assign w_in_fire     = in_valid && in_ready;
  assign w_diff        = in_data ^ r_hist;
  assign w_step_err_in = gray_n && r_hist_vld && ($countones(w_diff) != 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hist     <= '0;
      r_hist_vld <= 1'b0;
    end else if (w_in_fire) begin
      if (gray_n) r_hist <= in_data;
      r_hist_vld <= gray_n;
    end
  end
`else
  assign w_step_err_in = 1'b0;
`endif

  // A stage may load when it, or any stage below it, holds a bubble, or the output drains.
  always_comb begin
    logic hole;
    hole  = 1'b0;
    w_rdy = '0;
    for (int k = LAST; k >= 0; k--) begin
      hole     = hole | ~r_vld[k];
      w_rdy[k] = EN && (out_ready || hole);
    end
  end

  always_comb begin
    w_src_vld     = '0;
    w_src_mode    = '0;
    w_src_err     = '0;
    w_src_vld[0]  = in_valid;
    w_src_mode[0] = gray_n;
    w_src_err[0]  = w_step_err_in;
    w_src_data[0] = gray_n ? f_resolve(in_data, 0) : (in_data ^ (in_data >> 1));
    for (int k = 1; k < STAGES; k++) begin
      w_src_vld[k]  = r_vld[k-1];
      w_src_mode[k] = r_mode[k-1];
      w_src_err[k]  = r_err[k-1];
      w_src_data[k] = r_mode[k-1] ? f_resolve(r_data[k-1], k) : r_data[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld  <= '0;
      r_mode <= '0;
      r_err  <= '0;
      for (int k = 0; k < STAGES; k++) r_data[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          r_vld[k] <= w_src_vld[k];
          // Bubbles leave data untouched so an emptied output keeps its last word.
          if (w_src_vld[k]) begin
            r_data[k] <= w_src_data[k];
            r_mode[k] <= w_src_mode[k];
            r_err[k]  <= w_src_err[k];
          end
        end
      end
    end
  end

  assign in_ready   = w_rdy[0];
  assign out_valid  = EN && r_vld[LAST];
  assign out_data   = r_data[LAST];
  assign out_gray_n = r_mode[LAST];
  assign step_err   = out_valid && r_err[LAST];

endmodule

// File: tb/tb_gray_codec_pipe.sv
// Directed self-checking bench for gray_codec_pipe (8-bit/2-stage and 4-bit/4-stage instances).
module tb_gray_codec_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       a_en, a_in_valid, a_in_ready, a_gray_n;
  logic       a_out_valid, a_out_ready, a_out_gray_n, a_step_err;
  logic [7:0] a_in_data, a_out_data;
  logic       b_en, b_in_valid, b_in_ready, b_gray_n;
  logic       b_out_valid, b_out_ready, b_out_gray_n, b_step_err;
  logic [3:0] b_in_data, b_out_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [8:0] exp_q[$];

  gray_codec_pipe #(.WIDTH(8), .STAGES(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .EN(a_en), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .gray_n(a_gray_n), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_gray_n(a_out_gray_n), .step_err(a_step_err)
  );

  gray_codec_pipe #(.WIDTH(4), .STAGES(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .EN(b_en), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .gray_n(b_gray_n), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_gray_n(b_out_gray_n), .step_err(b_step_err)
  );

  function automatic logic [7:0] m_conv(input logic [7:0] d, input logic mode);
    logic [7:0] b;
    if (!mode) return d ^ (d >> 1);
    b[7] = d[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ d[i];
    return b;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; a_en = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_gray_n = 1'b0;
    a_out_ready = 1'b1;
    b_en = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_gray_n = 1'b0; b_out_ready = 1'b1;
    tick; tick;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", a_out_valid); end
    n_tests++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h want 00", a_out_data); end
    n_tests++; if (a_out_gray_n !== 1'b0) begin n_fail++; $display("FAIL reset_out_gray_n got %b want 0", a_out_gray_n); end
    n_tests++; if (a_step_err !== 1'b0) begin n_fail++; $display("FAIL reset_step_err got %b want 0", a_step_err); end
    n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_b_out_valid got %b want 0", b_out_valid); end
    rst_n = 1'b1;
    tick;
  endtask

  task automatic test_latency;
    a_in_valid = 1'b1; a_in_data = 8'h5A; a_gray_n = 1'b0;
    #1;
    n_tests++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready got %b want 1", a_in_ready); end
    tick;
    a_in_valid = 1'b0;
    #1;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_early_valid got %b want 0", a_out_valid); end
    tick;
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_valid got %b want 1", a_out_valid); end
    n_tests++; if (a_out_data !== 8'h77) begin n_fail++; $display("FAIL lat_b2g_data got %h want 77", a_out_data); end
    n_tests++; if (a_out_gray_n !== 1'b0) begin n_fail++; $display("FAIL lat_b2g_mode got %b want 0", a_out_gray_n); end
    tick;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_drained got %b want 0", a_out_valid); end
    a_in_valid = 1'b1; a_in_data = 8'h77; a_gray_n = 1'b1;
    tick;
    a_in_valid = 1'b0;
    tick;
    n_tests++; if (a_out_valid !== 1'b1) begin n_fail++; $display("FAIL lat_g2b_valid got %b want 1", a_out_valid); end
    n_tests++; if (a_out_data !== 8'h5A) begin n_fail++; $display("FAIL lat_g2b_data got %h want 5a", a_out_data); end
    n_tests++; if (a_out_gray_n !== 1'b1) begin n_fail++; $display("FAIL lat_g2b_mode got %b want 1", a_out_gray_n); end
    tick;
  endtask

  task automatic test_w4_s4;
    b_in_valid = 1'b1; b_in_data = 4'hF; b_gray_n = 1'b1;
    tick;
    b_in_valid = 1'b0;
    for (int c = 1; c < 4; c++) begin
      n_tests++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL w4_early_valid cyc %0d got %b want 0", c, b_out_valid); end
      tick;
    end
    n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL w4_valid got %b want 1", b_out_valid); end
    n_tests++; if (b_out_data !== 4'hA) begin n_fail++; $display("FAIL w4_g2b_data got %h want a", b_out_data); end
    b_in_valid = 1'b1; b_in_data = 4'h8; b_gray_n = 1'b0;
    tick;
    b_in_valid = 1'b0;
    tick; tick; tick;
    n_tests++; if (b_out_valid !== 1'b1) begin n_fail++; $display("FAIL w4_b2g_valid got %b want 1", b_out_valid); end
    n_tests++; if (b_out_data !== 4'hC) begin n_fail++; $display("FAIL w4_b2g_data got %h want c", b_out_data); end
    tick;
  endtask

  task automatic test_back_to_back;
    int sent = 0;
    int got  = 0;
    int cyc;
    logic fire;
    logic [8:0] e;
    exp_q.delete();
    for (cyc = 0; cyc < 600 && got < 512; cyc++) begin
      if (sent < 512) begin
        a_in_valid = 1'b1; a_in_data = sent[7:0]; a_gray_n = sent[8];
      end else a_in_valid = 1'b0;
      #1;
      if (a_out_valid && a_out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra got %b_%h want nothing", a_out_gray_n, a_out_data);
        end else begin
          e = exp_q.pop_front();
          if ({a_out_gray_n, a_out_data} !== e) begin
            n_fail++; $display("FAIL b2b_word %0d got %b_%h want %b_%h", got, a_out_gray_n, a_out_data, e[8], e[7:0]);
          end
        end
        got++;
      end
      fire = a_in_valid && a_in_ready;
      e    = {a_gray_n, m_conv(a_in_data, a_gray_n)};
      tick;
      if (fire) begin exp_q.push_back(e); sent++; end
    end
    a_in_valid = 1'b0;
    n_tests++; if (got != 512) begin n_fail++; $display("FAIL b2b_count got %0d want 512", got); end
    n_tests++; if (cyc != 514) begin n_fail++; $display("FAIL b2b_rate got %0d cycles want 514", cyc); end
  endtask

  task automatic test_backpressure;
    int sent = 0;
    int got  = 0;
    logic fire, prev_stall, saw_block;
    logic [9:0] prev;
    logic [8:0] e;
    logic [7:0] d;
    exp_q.delete();
    prev_stall = 1'b0; saw_block = 1'b0; prev = '0;
    for (int cyc = 0; cyc < 100 && got < 20; cyc++) begin
      a_out_ready = !(cyc >= 4 && cyc < 9);
      a_en        = !(cyc >= 14 && cyc < 17);
      d           = 8'h30 + sent[7:0];
      a_in_valid  = (sent < 20); a_in_data = d; a_gray_n = sent[0];
      #1;
      if (prev_stall && a_out_valid) begin
        n_tests++;
        if ({a_step_err, a_out_gray_n, a_out_data} !== prev) begin
          n_fail++; $display("FAIL bp_stable got %h want %h", {a_step_err, a_out_gray_n, a_out_data}, prev);
        end
      end
      if (!a_en) begin
        n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_en_valid got %b want 0", a_out_valid); end
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_en_ready got %b want 0", a_in_ready); end
      end
      if (!a_out_ready && a_in_valid && !a_in_ready) saw_block = 1'b1;
      if (a_out_valid && a_out_ready) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL bp_extra got %b_%h want nothing", a_out_gray_n, a_out_data);
        end else begin
          e = exp_q.pop_front();
          if ({a_out_gray_n, a_out_data} !== e) begin
            n_fail++; $display("FAIL bp_word %0d got %b_%h want %b_%h", got, a_out_gray_n, a_out_data, e[8], e[7:0]);
          end
        end
        got++;
      end
      prev_stall = a_out_valid && !a_out_ready;
      prev       = {a_step_err, a_out_gray_n, a_out_data};
      fire       = a_in_valid && a_in_ready;
      e          = {a_gray_n, m_conv(a_in_data, a_gray_n)};
      tick;
      if (fire) begin exp_q.push_back(e); sent++; end
    end
    a_in_valid = 1'b0; a_en = 1'b1; a_out_ready = 1'b1;
    n_tests++; if (got != 20) begin n_fail++; $display("FAIL bp_count got %0d want 20", got); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_leftover got %0d want 0", exp_q.size()); end
    n_tests++; if (saw_block !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_drop got %b want 1", saw_block); end
    tick;
  endtask

  task automatic test_reset_midop;
    a_out_ready = 1'b1; a_en = 1'b1;
    a_in_valid = 1'b1; a_in_data = 8'h11; a_gray_n = 1'b0;
    tick;
    a_in_data = 8'h22;
    tick;
    a_in_valid = 1'b0; rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid got %b want 0", a_out_valid); end
    n_tests++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data got %h want 00", a_out_data); end
    for (int c = 0; c < 4; c++) begin
      tick;
      n_tests++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ghost cyc %0d got %b want 0", c, a_out_valid); end
    end
  endtask

  task automatic test_step_check;
    logic [7:0] w [5];
    logic [4:0] se;
    int sent = 0;
    int got  = 0;
    w[0] = 8'h00; w[1] = 8'h01; w[2] = 8'h03; w[3] = 8'h00; w[4] = 8'h00;
`ifdef GRAY_CODEC_STEP_CHECK_EN
    se = 5'b11000;
`else
    se = 5'b00000;
`endif
    a_out_ready = 1'b1; a_en = 1'b1; a_gray_n = 1'b1;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      a_in_valid = (sent < 5);
      a_in_data  = (sent < 5) ? w[sent] : 8'h00;
      #1;
      if (a_out_valid && a_out_ready) begin
        n_tests++;
        if (a_step_err !== se[got]) begin
          n_fail++; $display("FAIL step_err word %0d got %b want %b", got, a_step_err, se[got]);
        end
        n_tests++;
        if (a_out_data !== m_conv(w[got], 1'b1)) begin
          n_fail++; $display("FAIL step_data word %0d got %h want %h", got, a_out_data, m_conv(w[got], 1'b1));
        end
        got++;
      end
      if (a_in_valid && a_in_ready) sent++;
      tick;
    end
    a_in_valid = 1'b0;
    n_tests++; if (got != 5) begin n_fail++; $display("FAIL step_count got %0d want 5", got); end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_w4_s4;
    test_back_to_back;
    test_backpressure;
    test_reset_midop;
    test_step_check;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/gray_codec_pipe.md
Name: gray_codec_pipe

Overview:
Parametrised, pipelined binary/Gray code converter with a per-transaction mode select and valid/ready handshaking on both sides.
- Successor to the fixed 4-bit combinational converter: generalised to WIDTH bits.
- The Gray-to-binary XOR prefix chain is split across STAGES register stages to meet timing at wide widths.
- Sits between counter/pointer producers (e.g. async FIFO pointers, encoders) and their consumers.

Parameters:
- WIDTH, 8, data width in bits; legal range 2..32.
- STAGES, 2, number of pipeline register stages; legal range 1..WIDTH; this is also the latency.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- EN  input  1  block enable; low freezes the pipeline.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word to convert.
- gray_n  input  1  mode: 0 = binary->Gray, 1 = Gray->binary; sampled with in_data.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  WIDTH  converted word.
- out_gray_n  output  1  mode the out_data word was converted with.
- step_err  output  1  Gray step-check flag aligned with out_data (see Optional Feature).

Behaviour:
- Reset (rst_n=0 at a clock edge): all stage valid bits cleared; all stage data, mode and flag registers cleared.
  - Resulting outputs: out_valid=0, out_data=0, out_gray_n=0, step_err=0.
  - Reset overrides EN and any handshake in the same cycle. In-flight words are discarded, not flushed.
- Transfer rules:
  - An input transfer occurs when in_valid && in_ready && EN.
  - An output transfer occurs when out_valid && out_ready.
- Pipeline:
  - STAGES register slots, each holding valid, data, mode and a partial result.
  - Stage k loads from stage k-1 when EN=1 and (stage k is empty or stage k is being drained this cycle).
  - in_ready = EN && (stage 1 empty || stage 1 advancing). in_ready is combinational from out_ready through the chain; no skid buffer.
  - Latency is exactly STAGES cycles from input transfer to out_valid, with no stalls.
  - Throughput is 1 word/cycle when out_ready is held at 1.
- Binary->Gray (gray_n=0):
  - g[W-1] = b[W-1]; g[i] = b[i+1] ^ b[i].
  - Computed in stage 1 and carried unchanged through the later stages.
- Gray->binary (gray_n=1):
  - b[W-1] = g[W-1]; b[i] = b[i+1] ^ g[i], resolved MSB-first.
  - Each stage resolves the next ceil(WIDTH/STAGES) bits. The resolved MSB carry is passed down with the word.
  - The final stage completes any remaining bits.
- Mixed modes may be interleaved word by word. Each word uses its own captured gray_n.
- EN=0:
  - in_ready=0 and no stage advances; contents are retained.
  - out_valid is forced to 0 (no output transfer); step_err is forced to 0.
  - When EN returns to 1, held words resume without loss or duplication.
- Stall: while out_valid=1 and out_ready=0, out_data, out_gray_n and step_err must stay stable. Upstream fills the empty stages, then in_ready drops.
- Empty pipeline: out_valid=0; out_data holds its last value (don't-care to the consumer).
- Simultaneous input and output transfers on a full pipeline are legal and sustain full rate.

Optional Feature:
- Macro: GRAY_CODEC_STEP_CHECK_EN.
- When defined:
  - On each input transfer with gray_n=1, in_data is compared with the previously accepted gray_n=1 word.
  - The error is set when popcount(current ^ previous) != 1, including the case where the two words are identical.
  - The error travels with the word and appears on step_err, qualified by out_valid.
  - The first gray_n=1 word after reset, and the first after any gray_n=0 word, is never flagged.
  - The history register clears on reset.
- When not defined: the step_err port still exists and is tied to 0; no history register is built.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: in_data=0x5A, gray_n=0 -> out_data=0x77, out_gray_n=0, exactly 2 cycles after the transfer.
- Same configuration: in_data=0x77, gray_n=1 -> out_data=0x5A. Then back-to-back sweep of 0x00..0xFF in both modes -> one output per cycle, all values correct and in order.
- WIDTH=4, STAGES=4: gray_n=1, in_data=0xF -> out_data=0xA after 4 cycles. Binary 0x8 with gray_n=0 -> 0xC.
- Backpressure: hold out_ready=0 for 5 cycles while streaming -> in_ready falls after the stages fill, out_data stays stable, no word lost or duplicated. Also toggle EN=0 for 3 cycles mid-stream -> out_valid=0 during that time and the stream resumes intact.
- Reset mid-operation: assert rst_n=0 for 1 cycle with 2 words in flight -> the next cycle shows out_valid=0 and out_data=0, and the in-flight words never appear.
- With GRAY_CODEC_STEP_CHECK_EN defined: gray_n=1 words 0x00, 0x01, 0x03, 0x00, 0x00 -> step_err = 0, 0, 0, 1, 1. Without the macro, step_err=0 throughout.
